task_dispatch_queue: RTL and testbench
======================================

// Module: task_dispatch_queue
// PURPOSE
//  Buffers incoming tasks (priority, duration) and issues them one at a time to task_scheduler,
//  which is the next stage downstream. Always issues the highest-priority entry first and breaks
//  ties by issuing the oldest entry first. Holds the issue back while all cores are busy, and
//  discards zero-length tasks.
// PARAMETERS
//  DEPTH       8   queue entries (>=2)
//  PRIO_W      3   priority width; larger value = more urgent
//  DUR_W       8   duration width
//  NUM_CORES   4   width of core_busy
//  AGE_PERIOD  16  cycles per priority promotion (only with TASK_QUEUE_AGING_EN)
// PORTS
//  clk           in   1                  clock, rising edge
//  reset_n       in   1                  asynchronous, active-low reset
//  in_valid      in   1                  upstream offers a task
//  in_ready      out  1                  queue can accept (= !q_full)
//  in_priority   in   PRIO_W             priority of the offered task
//  in_duration   in   DUR_W              duration of the offered task
//  core_busy     in   NUM_CORES          busy map from task_scheduler
//  out_valid     out  1                  task presented to the scheduler
//  out_ready     in   1                  scheduler takes the task
//  out_priority  out  PRIO_W             priority of the presented entry (aged value if aging on)
//  out_duration  out  DUR_W              duration of the presented entry
//  q_count       out  $clog2(DEPTH+1)    number of valid entries
//  q_full        out  1                  q_count == DEPTH
//  q_empty       out  1                  q_count == 0
//  drop_count    out  8                  zero-duration tasks discarded; saturates at 255
// BEHAVIOUR
//  - Reset (reset_n=0, async): all entries invalid, q_count=0, drop_count=0, q_empty=1, q_full=0,
//    out_valid=0. The reset clears any in-flight task. in_ready=1 from the first edge after release.
//  - Storage: compacted array; index 0 = oldest; tail index = q_count.
//  - Push: fires when in_valid && in_ready at a clk edge. Entry is written at index (q_count - pop).
//    If in_duration==0, the task is accepted but not stored, and drop_count increments (saturating).
//  - Select: combinational over the valid entries. Highest priority wins; on equal priority the
//    lowest index (oldest) wins.
//  - out_valid = !q_empty && (core_busy != all-ones). out_priority/out_duration = selected entry.
//    When out_valid=0, out_priority/out_duration are 0.
//  - Pop: fires when out_valid && out_ready. The selected entry is removed, and entries above it
//    shift down by one in the same edge.
//  - Latency: a pushed task can be presented no earlier than the cycle after its push edge.
//    There is no empty-queue bypass.
//  - Push and pop in the same cycle: both take effect; q_count is unchanged. When the queue is
//    full, in_ready=0 even if a pop is occurring (no full-queue pass-through).
//  - Outputs hold steady while out_valid && !out_ready.
//  - core_busy going all-ones drops out_valid combinationally; the entry is kept.
//  - q_count/q_full/q_empty are registered-state derived. No wrap: the count never exceeds DEPTH.
// CONFIGURATION
//  TASK_QUEUE_AGING_EN defined:
//   - Each entry carries a $clog2(AGE_PERIOD)-bit age counter, cleared on push and carried with
//     the entry when it shifts.
//   - Each cycle the entry is not popped, its counter increments. When the counter is at
//     AGE_PERIOD-1, the priority increments by 1 (saturating at 2^PRIO_W-1) and the counter
//     returns to 0.
//   - Selection and out_priority use the aged priority.
//  TASK_QUEUE_AGING_EN undefined:
//   - No age counters; priority is static as pushed.
// TESTING
//  1. Reset: hold reset_n=0 mid-burst with 3 entries queued -> q_count=0, out_valid=0,
//     drop_count=0, in_ready=1 after release.
//  2. Ordering: push (p3,d10), (p2,d20), (p1,d15), (p0,d30), out_ready=1, core_busy=0000 ->
//     issued in order 3/10, 2/20, 1/15, 0/30, one per cycle.
//  3. Ties and full: push 8 tasks p2 with d1..d8 -> q_full=1, in_ready=0, and a 9th push is
//     ignored. Pops then yield d1..d8 in order.
//  4. Back-pressure: 2 entries queued, core_busy=1111 -> out_valid=0, q_count stays 2.
//     Set core_busy=0111 -> out_valid=1 in the same cycle.
//  5. Simultaneous: q_count=4, push (p5,d7) and pop in the same cycle -> q_count=4, and the
//     next issued task is p5/d7.
//  6. Drop and aging: push (p1,d0) -> drop_count=1, q_count unchanged.
//     With TASK_QUEUE_AGING_EN: push (p0,d9), hold out_ready=0 for 32 cycles -> out_priority=2.

Source files
------------

// File: rtl/task_dispatch_queue.sv
// Priority task buffer feeding task_scheduler: highest priority first, oldest first on ties.
// Define TASK_QUEUE_AGING_EN to promote waiting entries by one level every AGE_PERIOD cycles.
module task_dispatch_queue #(
  parameter int DEPTH      = 8,
  parameter int PRIO_W     = 3,
  parameter int DUR_W      = 8,
  parameter int NUM_CORES  = 4,
  parameter int AGE_PERIOD = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PRIO_W-1:0]          in_priority,
  input  logic [DUR_W-1:0]           in_duration,
  input  logic [NUM_CORES-1:0]       core_busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PRIO_W-1:0]          out_priority,
  output logic [DUR_W-1:0]           out_duration,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic                       q_full,
  output logic                       q_empty,
  output logic [7:0]                 drop_count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [PRIO_W-1:0] PRIO_MAX = '1;

  if (DEPTH < 2 || AGE_PERIOD < 2) begin : g_bad_params
    $error("task_dispatch_queue: DEPTH and AGE_PERIOD must be at least 2");
  end

  logic [PRIO_W-1:0] prio_q [DEPTH];
  logic [DUR_W-1:0]  dur_q  [DEPTH];
  logic [PRIO_W-1:0] prio_d [DEPTH];
  logic [DUR_W-1:0]  dur_d  [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [CNT_W-1:0]  wr_idx;
  logic [7:0]        drop_q;
  logic [7:0]        drop_d;
  logic [IDX_W-1:0]  sel_idx;
  logic [PRIO_W-1:0] sel_prio;
  logic [DUR_W-1:0]  sel_dur;
  logic              push_fire;
  logic              drop_fire;
  logic              store;
  logic              pop_fire;

`ifdef TASK_QUEUE_AGING_EN
  localparam int AGE_W = $clog2(AGE_PERIOD);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(AGE_PERIOD - 1);

  logic [AGE_W-1:0] age_q [DEPTH];
  logic [AGE_W-1:0] age_d [DEPTH];
`endif

  assign q_count   = count_q;
  assign q_empty   = (count_q == '0);
  assign q_full    = (count_q == CNT_W'(DEPTH));
  assign in_ready  = !q_full;
  assign out_valid = !q_empty && (core_busy != '1);

  // Strict '>' keeps the lowest (oldest) index on equal priority.
  always_comb begin
    sel_idx  = '0;
    sel_prio = prio_q[0];
    sel_dur  = dur_q[0];
    for (int i = 1; i < DEPTH; i++) begin
      if ((i < int'(count_q)) && (prio_q[i] > sel_prio)) begin
        sel_idx  = IDX_W'(i);
        sel_prio = prio_q[i];
        sel_dur  = dur_q[i];
      end
    end
  end

  assign out_priority = out_valid ? sel_prio : '0;
  assign out_duration = out_valid ? sel_dur  : '0;

  assign push_fire = in_valid && in_ready;
  assign drop_fire = push_fire && (in_duration == '0);
  assign store     = push_fire && !drop_fire;
  assign pop_fire  = out_valid && out_ready;
  assign wr_idx    = count_q - CNT_W'(pop_fire);
  assign count_d   = count_q + CNT_W'(store) - CNT_W'(pop_fire);
  assign drop_d    = (drop_fire && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      prio_d[i] = prio_q[i];
      dur_d[i]  = dur_q[i];
`ifdef TASK_QUEUE_AGING_EN
      age_d[i]  = age_q[i];
`endif
    end

    if (pop_fire) begin
      for (int i = 0; i < DEPTH-1; i++) begin
        if (i >= int'(sel_idx)) begin
          prio_d[i] = prio_q[i+1];
          dur_d[i]  = dur_q[i+1];
`ifdef TASK_QUEUE_AGING_EN
          age_d[i]  = age_q[i+1];
`endif
        end
      end
    end

`ifdef TASK_QUEUE_AGING_EN
    // Survivors sit below wr_idx after the shift; only they age this cycle.
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(wr_idx)) begin
        if (age_d[i] == AGE_LAST) begin
          age_d[i] = '0;
          if (prio_d[i] != PRIO_MAX) begin
            prio_d[i] = prio_d[i] + 1'b1;
          end
        end else begin
          age_d[i] = age_d[i] + 1'b1;
        end
      end
    end
`endif

    for (int i = 0; i < DEPTH; i++) begin
      if (store && (i == int'(wr_idx))) begin
        prio_d[i] = in_priority;
        dur_d[i]  = in_duration;
`ifdef TASK_QUEUE_AGING_EN
        age_d[i]  = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      drop_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        prio_q[i] <= '0;
        dur_q[i]  <= '0;
`ifdef TASK_QUEUE_AGING_EN
        age_q[i]  <= '0;
`endif
      end
    end else begin
      count_q <= count_d;
      drop_q  <= drop_d;
      for (int i = 0; i < DEPTH; i++) begin
        prio_q[i] <= prio_d[i];
        dur_q[i]  <= dur_d[i];
`ifdef TASK_QUEUE_AGING_EN
        age_q[i]  <= age_d[i];
`endif
      end
    end
  end

  assign drop_count = drop_q;

endmodule

// File: tb/tb_task_dispatch_queue.sv
// Self-checking bench for task_dispatch_queue: vector table plus a queue-based reference model.
// Build with TASK_QUEUE_AGING_EN defined to exercise the aging checks.
module tb_task_dispatch_queue;

  localparam int DEPTH = 8;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_priority;
  logic [7:0] in_duration;
  logic [3:0] core_busy;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_priority;
  logic [7:0] out_duration;
  logic [3:0] q_count;
  logic       q_full;
  logic       q_empty;
  logic [7:0] drop_count;

  task_dispatch_queue dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_priority  (in_priority),
    .in_duration  (in_duration),
    .core_busy    (core_busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_priority (out_priority),
    .out_duration (out_duration),
    .q_count      (q_count),
    .q_full       (q_full),
    .q_empty      (q_empty),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    int         p;
    int         d;
    logic       ordy;
    logic [3:0] busy;
    logic       ev;
    int         ep;
    int         ed;
    int         ec;
    int         edrop;
  } vec_t;

  typedef struct {
    int p;
    int d;
    int age;
  } ent_t;

  vec_t vecs[$];
  ent_t mq[$];
  int   mdrop;
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic addv(input logic iv, input int p, input int d, input logic ordy,
                      input logic [3:0] busy, input logic ev, input int ep, input int ed,
                      input int ec, input int edrop);
    vec_t v;
    v = '{iv, p, d, ordy, busy, ev, ep, ed, ec, edrop};
    vecs.push_back(v);
  endtask

  function automatic int msel();
    int b = 0;
    for (int i = 1; i < mq.size(); i++)
      if (mq[i].p > mq[b].p) b = i;
    return b;
  endfunction

  // Drive at the falling edge, sample 4 time units later (1 before the rising edge).
  task automatic apply(input logic iv, input int p, input int d, input logic ordy,
                       input logic [3:0] busy);
    in_valid    = iv;
    in_priority = 3'(p);
    in_duration = 8'(d);
    out_ready   = ordy;
    core_busy   = busy;
    #4;
  endtask

  task automatic sb_check();
    logic mv;
    int   b;
    mv = (mq.size() != 0) && (core_busy != 4'hF);
    chk("sb_out_valid", 32'(out_valid), 32'(mv));
    chk("sb_q_count", 32'(q_count), mq.size());
    chk("sb_drop_count", 32'(drop_count), mdrop);
    if (mv) begin
      b = msel();
      chk("sb_out_priority", 32'(out_priority), mq[b].p);
      chk("sb_out_duration", 32'(out_duration), mq[b].d);
    end else begin
      chk("sb_idle_outputs", 32'({out_priority, out_duration}), 0);
    end
  endtask

  task automatic commit();
    logic mv;
    logic pop;
    logic push;
    int   b;
    ent_t e;
    mv   = (mq.size() != 0) && (core_busy != 4'hF);
    pop  = mv && out_ready;
    push = in_valid && (mq.size() < DEPTH);
    b    = msel();
    @(posedge clk);
    if (pop) mq.delete(b);
`ifdef TASK_QUEUE_AGING_EN
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].age == 15) begin
        mq[i].age = 0;
        if (mq[i].p < 7) mq[i].p = mq[i].p + 1;
      end else begin
        mq[i].age = mq[i].age + 1;
      end
    end
`endif
    if (push) begin
      if (in_duration == 8'd0) begin
        if (mdrop < 255) mdrop++;
      end else begin
        e = '{int'(in_priority), int'(in_duration), 0};
        mq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    mdrop  = 0;

    // ordering
    addv(1, 3, 10, 0, 4'h0, 0, 0, 0, 0, 0);
    addv(1, 2, 20, 0, 4'h0, 1, 3, 10, 1, 0);
    addv(1, 1, 15, 0, 4'h0, 1, 3, 10, 2, 0);
    addv(1, 0, 30, 0, 4'h0, 1, 3, 10, 3, 0);
    addv(0, 0, 0, 1, 4'h0, 1, 3, 10, 4, 0);
    addv(0, 0, 0, 1, 4'h0, 1, 2, 20, 3, 0);
    addv(0, 0, 0, 1, 4'h0, 1, 1, 15, 2, 0);
    addv(0, 0, 0, 1, 4'h0, 1, 0, 30, 1, 0);
    addv(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    // back-pressure
    addv(1, 4, 40, 0, 4'h0, 0, 0, 0, 0, 0);
    addv(1, 6, 60, 0, 4'hF, 0, 0, 0, 1, 0);
    addv(0, 0, 0, 1, 4'hF, 0, 0, 0, 2, 0);
    addv(0, 0, 0, 1, 4'hF, 0, 0, 0, 2, 0);
    addv(0, 0, 0, 0, 4'h7, 1, 6, 60, 2, 0);
    addv(0, 0, 0, 1, 4'h7, 1, 6, 60, 2, 0);
    addv(0, 0, 0, 1, 4'h0, 1, 4, 40, 1, 0);
    addv(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    // simultaneous push and pop
    addv(1, 1, 11, 0, 4'h0, 0, 0, 0, 0, 0);
    addv(1, 2, 12, 0, 4'h0, 1, 1, 11, 1, 0);
    addv(1, 1, 13, 0, 4'h0, 1, 2, 12, 2, 0);
    addv(1, 3, 14, 0, 4'h0, 1, 2, 12, 3, 0);
    addv(1, 5, 7, 1, 4'h0, 1, 3, 14, 4, 0);
    addv(0, 0, 0, 0, 4'h0, 1, 5, 7, 4, 0);
    addv(0, 0, 0, 1, 4'h0, 1, 5, 7, 4, 0);
    addv(0, 0, 0, 1, 4'h0, 1, 2, 12, 3, 0);
    addv(0, 0, 0, 1, 4'h0, 1, 1, 11, 2, 0);
    addv(0, 0, 0, 1, 4'h0, 1, 1, 13, 1, 0);
    addv(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    // zero-duration drops
    addv(1, 1, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1);
    addv(1, 2, 5, 0, 4'h0, 0, 0, 0, 0, 1);
    addv(1, 1, 0, 0, 4'h0, 1, 2, 5, 1, 1);
    addv(0, 0, 0, 0, 4'h0, 1, 2, 5, 1, 2);
    addv(0, 0, 0, 1, 4'h0, 1, 2, 5, 1, 2);
    addv(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 2);

    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_priority = '0;
    in_duration = '0;
    out_ready   = 1'b0;
    core_busy   = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_q_empty", 32'(q_empty), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // reset in the middle of a burst
    apply(1, 1, 1, 0, 4'h0); sb_check(); commit();
    apply(1, 2, 2, 0, 4'h0); sb_check(); commit();
    apply(1, 1, 0, 0, 4'h0); sb_check(); commit();
    apply(1, 3, 3, 0, 4'h0); sb_check(); commit();
    chk("pre_rst_count", 32'(q_count), 3);
    in_valid    = 1'b1;
    in_priority = 3'd4;
    in_duration = 8'd4;
    reset_n     = 1'b0;
    #1;
    chk("mid_rst_count", 32'(q_count), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_drop", 32'(drop_count), 0);
    chk("mid_rst_q_full", 32'(q_full), 0);
    @(posedge clk);
    @(negedge clk);
    mq.delete();
    mdrop    = 0;
    in_valid = 1'b0;
    reset_n  = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_count", 32'(q_count), 0);
    @(negedge clk);

    foreach (vecs[i]) begin
      apply(vecs[i].iv, vecs[i].p, vecs[i].d, vecs[i].ordy, vecs[i].busy);
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_out_priority", i), 32'(out_priority), vecs[i].ep);
      chk($sformatf("vec%0d_out_duration", i), 32'(out_duration), vecs[i].ed);
      chk($sformatf("vec%0d_q_count", i), 32'(q_count), vecs[i].ec);
      chk($sformatf("vec%0d_drop_count", i), 32'(drop_count), vecs[i].edrop);
      sb_check();
      commit();
    end

    // ties and full queue
    for (int k = 1; k <= 8; k++) begin
      apply(1, 2, k, 0, 4'h0); sb_check(); commit();
    end
    apply(1, 7, 99, 0, 4'h0);
    chk("full_q_full", 32'(q_full), 1);
    chk("full_in_ready", 32'(in_ready), 0);
    sb_check(); commit();
    chk("full_ninth_ignored", 32'(q_count), 8);
    apply(1, 7, 99, 1, 4'h0);
    chk("full_pop_in_ready", 32'(in_ready), 0);
    chk("tie_order_1", 32'(out_duration), 1);
    sb_check(); commit();
    chk("full_pop_count", 32'(q_count), 7);
    for (int k = 2; k <= 8; k++) begin
      apply(0, 0, 0, 1, 4'h0);
      chk($sformatf("tie_order_%0d", k), 32'(out_duration), k);
      sb_check(); commit();
    end
    apply(0, 0, 0, 0, 4'h0);
    chk("drained_q_empty", 32'(q_empty), 1);
    sb_check(); commit();

    // drop counter saturation
    for (int k = 0; k < 256; k++) begin
      apply(1, 1, 0, 0, 4'h0); commit();
    end
    apply(0, 0, 0, 0, 4'h0);
    chk("drop_saturate", 32'(drop_count), 255);
    sb_check(); commit();

    // aging: a p0 entry held for 31 and 32 cycles
    apply(1, 0, 9, 0, 4'h0); sb_check(); commit();
    for (int k = 0; k < 31; k++) begin
      apply(0, 0, 0, 0, 4'h0); sb_check(); commit();
    end
    apply(0, 0, 0, 0, 4'h0);
`ifdef TASK_QUEUE_AGING_EN
    chk("age_31_cycles", 32'(out_priority), 1);
`else
    chk("age_31_cycles", 32'(out_priority), 0);
`endif
    commit();
    apply(0, 0, 0, 0, 4'h0);
`ifdef TASK_QUEUE_AGING_EN
    chk("age_32_cycles", 32'(out_priority), 2);
`else
    chk("age_32_cycles", 32'(out_priority), 0);
`endif
    chk("age_duration", 32'(out_duration), 9);
    sb_check(); commit();
    apply(0, 0, 0, 1, 4'h0); sb_check(); commit();
    apply(0, 0, 0, 0, 4'h0); sb_check(); commit();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
